// File: rtl/mips_cpu_bus_arbiter_pkg.sv
// Shared types for the CPU bus arbiter: FSM states,
// grant owner and the fetch/data tie-break helper.
package mips_cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } bus_state_e;

  typedef enum logic {
    GRANT_FETCH,
    GRANT_DATA
  } grant_e;

  localparam logic [3:0]  BE_ALL    = 4'b1111;
  localparam logic [3:0]  BE_NONE   = 4'b0000;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  // On a tie the requester that lost last time wins.
  function automatic grant_e arb_pick(
    input logic   f,
    input logic   d,
    input grant_e last
  );
    if (f && d) begin
      return (last == GRANT_DATA) ? GRANT_FETCH
                                  : GRANT_DATA;
    end
    return d ? GRANT_DATA : GRANT_FETCH;
  endfunction

endpackage

// File: rtl/mips_cpu_bus_arbiter_if.sv
// CPU-side request ports and Avalon master bus
// of the arbiter, bundled with direction views.
interface mips_cpu_bus_arbiter_if;

  logic        ifetch_req;
  logic [31:0] ifetch_addr;
  logic [31:0] ifetch_rdata;
  logic        ifetch_done;
  logic        ifetch_err;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_done;
  logic        dmem_err;

  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        waitrequest;

  logic        busy;

  modport master (
    input  ifetch_req,
    input  ifetch_addr,
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_be,
    input  readdata,
    input  waitrequest,
    output ifetch_rdata,
    output ifetch_done,
    output ifetch_err,
    output dmem_rdata,
    output dmem_done,
    output dmem_err,
    output address,
    output read,
    output write,
    output writedata,
    output byteenable,
    output busy
  );

  modport slave (
    output ifetch_req,
    output ifetch_addr,
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    output dmem_be,
    output readdata,
    output waitrequest,
    input  ifetch_rdata,
    input  ifetch_done,
    input  ifetch_err,
    input  dmem_rdata,
    input  dmem_done,
    input  dmem_err,
    input  address,
    input  read,
    input  write,
    input  writedata,
    input  byteenable,
    input  busy
  );

endinterface

// File: rtl/mips_cpu_bus_arbiter_wait_timer.sv
// Counts stalled Avalon cycles and flags the cycle
// whose stall would reach the configured limit.
module bus_wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mips_cpu_bus_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single
// Avalon master with wait timeout and one-cycle reply.
module mips_cpu_bus_arbiter
  import mips_cpu_bus_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_cpu_bus_arbiter_if.master bus
);

  bus_state_e  state_q;
  bus_state_e  state_d;
  grant_e      grant_q;
  grant_e      win;
  logic [31:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] frdata_q;
  logic [31:0] drdata_q;
  logic        err_q;

  logic req_any;
  logic take;
  logic skip;
  logic in_acc;
  logic wait_en;
  logic expire;
  logic finish;
  logic resp_f;
  logic resp_d;

  assign req_any = bus.ifetch_req | bus.dmem_req;
  assign win     = arb_pick(bus.ifetch_req,
                            bus.dmem_req, grant_q);
  assign take    = (state_q == IDLE) && req_any;
  assign skip    = (win == GRANT_DATA) &&
                   (bus.dmem_be == BE_NONE);
  assign in_acc  = (state_q == ACCESS);
  assign wait_en = in_acc && bus.waitrequest;
  assign finish  = in_acc &&
                   (!bus.waitrequest || expire);

  bus_wait_timer #(
    .LIMIT (WAIT_LIMIT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (!in_acc),
    .en_i     (wait_en),
    .expire_o (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d = skip ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (finish) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q  <= GRANT_DATA;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
      frdata_q <= '0;
      drdata_q <= '0;
      err_q    <= 1'b0;
    end else if (take) begin
      grant_q <= win;
      err_q   <= 1'b0;
      if (win == GRANT_FETCH) begin
        addr_q  <= bus.ifetch_addr & WORD_MASK;
        we_q    <= 1'b0;
        wdata_q <= '0;
        be_q    <= BE_ALL;
      end else begin
        addr_q  <= bus.dmem_addr & WORD_MASK;
        we_q    <= bus.dmem_we;
        wdata_q <= bus.dmem_wdata;
        be_q    <= bus.dmem_be;
      end
      if (skip) begin
        drdata_q <= '0;
      end
    end else if (finish) begin
      // A timed-out transfer returns zero data.
      err_q <= expire;
      if (grant_q == GRANT_FETCH) begin
        frdata_q <= expire ? '0 : bus.readdata;
      end else begin
        drdata_q <= expire ? '0 : bus.readdata;
      end
    end
  end

  always_comb begin
    resp_f = (state_q == RESP) &&
             (grant_q == GRANT_FETCH);
    resp_d = (state_q == RESP) &&
             (grant_q == GRANT_DATA);
    bus.address      = addr_q;
    bus.writedata    = wdata_q;
    bus.byteenable   = be_q;
    bus.read         = in_acc && !we_q;
    bus.write        = in_acc && we_q;
    bus.busy         = (state_q != IDLE);
    bus.ifetch_done  = resp_f;
    bus.ifetch_err   = resp_f && err_q;
    bus.ifetch_rdata = frdata_q;
    bus.dmem_done    = resp_d;
    bus.dmem_err     = resp_d && err_q;
    bus.dmem_rdata   = drdata_q;
  end

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Bench for mips_cpu_bus_arbiter: vector table, corner sequences
// and random transactions against a transaction-level model.
module tb_mips_cpu_bus_arbiter;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mips_cpu_bus_arbiter_if bus();

  mips_cpu_bus_arbiter #(
    .WAIT_LIMIT (LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        f;
    logic        d;
    logic [31:0] faddr;
    logic [31:0] daddr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rd;
    logic        first_data;
    int          cyc;
    logic        err;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic        m_last_data;
  logic [31:0] m_frd;
  logic [31:0] m_drd;
  logic        m_drd_known;
  vec_t        tbl [10];

  task automatic chk(input string nm,
                     input logic [71:0] act,
                     input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ifetch_req  = 1'b0;
    bus.ifetch_addr = '0;
    bus.dmem_req    = 1'b0;
    bus.dmem_we     = 1'b0;
    bus.dmem_addr   = '0;
    bus.dmem_wdata  = '0;
    bus.dmem_be     = '0;
    bus.readdata    = '0;
    bus.waitrequest = 1'b0;
  endtask

  task automatic model_reset();
    m_last_data = 1'b1;
    m_frd       = '0;
    m_drd       = '0;
    m_drd_known = 1'b1;
  endtask

  // Drives one or two requests until each completes.
  task automatic run_vec(input vec_t v, input string nm);
    logic        f_pend;
    logic        d_pend;
    logic        cur_d;
    logic        rd_op;
    logic        eerr;
    logic        rchk;
    logic [31:0] ea;
    logic [31:0] erd;
    logic [31:0] ard;
    logic [3:0]  eb;
    int          c;
    int          start;
    int          nbus;
    int          ecyc;
    f_pend = v.f;
    d_pend = v.d;
    cur_d  = v.d && (!v.f || v.first_data);
    bus.ifetch_addr = v.faddr;
    bus.dmem_addr   = v.daddr;
    bus.dmem_we     = v.we;
    bus.dmem_be     = v.be;
    bus.dmem_wdata  = v.wdata;
    bus.readdata    = v.rd;
    bus.waitrequest = 1'b0;
    bus.ifetch_req  = v.f;
    bus.dmem_req    = v.d;
    c = 0;
    start = 0;
    nbus = 0;
    while ((f_pend || d_pend) && c < 60) begin
      step();
      c++;
      ea = cur_d ? v.daddr : v.faddr;
      ea[1:0] = 2'b00;
      eb = cur_d ? v.be : 4'hF;
      rd_op = !cur_d || !v.we;
      if (bus.read || bus.write) begin
        chk({nm, "/bus"},
            {bus.address, bus.read, bus.write,
             bus.byteenable},
            {ea, rd_op, !rd_op, eb});
        if (!rd_op) begin
          chk({nm, "/wdata"}, bus.writedata, v.wdata);
        end
        bus.waitrequest = (nbus < v.waits);
        nbus++;
      end else begin
        bus.waitrequest = 1'b0;
      end
      if (bus.ifetch_done || bus.dmem_done) begin
        ecyc = (cur_d && v.be == 4'h0) ? 0 : v.cyc;
        eerr = (ecyc != 0) && v.err;
        erd  = (eerr || ecyc == 0) ? 32'h0 : v.rd;
        rchk = rd_op || eerr || (ecyc == 0);
        chk({nm, "/who"},
            {bus.ifetch_done, bus.dmem_done},
            {!cur_d, cur_d});
        chk({nm, "/buscyc"}, nbus, ecyc);
        chk({nm, "/latency"}, c, start + ecyc + 1);
        chk({nm, "/err"},
            cur_d ? bus.dmem_err : bus.ifetch_err, eerr);
        ard = cur_d ? bus.dmem_rdata : bus.ifetch_rdata;
        if (rchk) begin
          chk({nm, "/rdata"}, ard, erd);
        end
        if (cur_d) begin
          d_pend = 1'b0;
          bus.dmem_req = 1'b0;
          m_drd = erd;
          m_drd_known = rchk;
        end else begin
          f_pend = 1'b0;
          bus.ifetch_req = 1'b0;
          m_frd = erd;
        end
        m_last_data = cur_d;
        cur_d = !cur_d;
        start = c + 1;
        nbus = 0;
      end
    end
    chk({nm, "/timeout"}, {f_pend, d_pend}, 2'b00);
    bus.ifetch_req  = 1'b0;
    bus.dmem_req    = 1'b0;
    bus.waitrequest = 1'b0;
    step();
    chk({nm, "/idle"},
        {bus.busy, bus.ifetch_done, bus.dmem_done,
         bus.read, bus.write}, 5'b0);
    chk({nm, "/hold_f"}, bus.ifetch_rdata, m_frd);
    if (m_drd_known) begin
      chk({nm, "/hold_d"}, bus.dmem_rdata, m_drd);
    end
  endtask

  initial begin
    vec_t v;
    int   sel;
    tbl[0] = '{1'b1, 1'b1, 32'hBFC00000, 32'h00001000,
               1'b0, 4'hF, 32'h0, 0, 32'h24020005,
               1'b0, 1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 32'hBFC00000, 32'h0,
               1'b0, 4'hF, 32'h0, 0, 32'h24020005,
               1'b0, 1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 32'hBFC00008, 32'h00002004,
               1'b0, 4'hF, 32'h0, 2, 32'hCAFEF00D,
               1'b1, 3, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 32'h0, 32'h00001003,
               1'b1, 4'b0100, 32'h00AB0000, 3, 32'h0,
               1'b1, 4, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 32'h00000010, 32'h0,
               1'b0, 4'hF, 32'h0, 9, 32'h12345678,
               1'b0, 4, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 32'h0, 32'h00002000,
               1'b0, 4'h0, 32'h0, 0, 32'hDEADBEEF,
               1'b1, 0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 32'h0, 32'h00003002,
               1'b0, 4'b0011, 32'h0, 1, 32'hA5A5A5A5,
               1'b1, 2, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 32'h0, 32'h00000FFC,
               1'b1, 4'hF, 32'h13572468, 7, 32'h0,
               1'b1, 4, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 32'h00000020, 32'h00004000,
               1'b0, 4'h0, 32'h0, 0, 32'h0BADBEEF,
               1'b0, 1, 1'b0};
    tbl[9] = '{1'b1, 1'b1, 32'h00000024, 32'h00004008,
               1'b1, 4'hF, 32'h89ABCDEF, 4, 32'h76543210,
               1'b0, 4, 1'b1};

    clear_inputs();
    reset = 1'b1;
    step();
    step();
    chk("rst_bus",
        {bus.address, bus.writedata, bus.byteenable,
         bus.read, bus.write, bus.busy}, 72'h0);
    chk("rst_resp",
        {bus.ifetch_rdata, bus.dmem_rdata,
         bus.ifetch_done, bus.ifetch_err,
         bus.dmem_done, bus.dmem_err}, 72'h0);
    reset = 1'b0;
    model_reset();
    step();

    for (int i = 0; i < 10; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Fetch request withdrawn while the bus cycle stalls.
    clear_inputs();
    bus.ifetch_addr = 32'h00000100;
    bus.readdata    = 32'h55AA55AA;
    bus.waitrequest = 1'b1;
    bus.ifetch_req  = 1'b1;
    step();
    chk("drop_rd0", {bus.read, bus.address},
        {1'b1, 32'h00000100});
    bus.ifetch_req = 1'b0;
    step();
    chk("drop_rd1", {bus.read, bus.ifetch_done},
        2'b10);
    bus.waitrequest = 1'b0;
    step();
    chk("drop_done",
        {bus.ifetch_done, bus.ifetch_err,
         bus.ifetch_rdata, bus.read},
        {2'b10, 32'h55AA55AA, 1'b0});
    step();
    chk("drop_idle", {bus.busy, bus.ifetch_done},
        2'b00);
    m_last_data = 1'b0;
    m_frd = 32'h55AA55AA;

    // Reset lands while a data read is stalled.
    clear_inputs();
    bus.dmem_addr   = 32'h00000040;
    bus.dmem_be     = 4'hF;
    bus.waitrequest = 1'b1;
    bus.dmem_req    = 1'b1;
    step();
    chk("rma_read", bus.read, 1'b1);
    step();
    reset = 1'b1;
    step();
    chk("rma_off",
        {bus.read, bus.write, bus.busy,
         bus.ifetch_done, bus.dmem_done}, 5'b0);
    reset = 1'b0;
    clear_inputs();
    step();
    chk("rma_nodone",
        {bus.busy, bus.dmem_done, bus.dmem_rdata},
        33'h0);
    model_reset();

    for (int i = 0; i < 60; i++) begin
      sel     = int'($urandom_range(1, 3));
      v.f     = sel[0];
      v.d     = sel[1];
      v.faddr = $urandom;
      v.daddr = $urandom;
      v.we    = 1'($urandom_range(0, 1));
      v.be    = ($urandom_range(0, 3) == 0) ? 4'h0 :
                4'($urandom_range(1, 15));
      v.wdata = $urandom;
      v.waits = int'($urandom_range(0, 6));
      v.rd    = $urandom;
      v.first_data = (v.f && v.d) ? !m_last_data : v.d;
      v.err   = (v.waits >= LIMIT);
      v.cyc   = v.err ? LIMIT : v.waits + 1;
      run_vec(v, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_cpu_bus_arbiter.md
MIPS_CPU_BUS_ARBITER -- requirements
Module: mips_cpu_bus_arbiter

Interface
- REQ-001 SHALL have parameter: WAIT_LIMIT, 255, max consecutive waitrequest cycles before timeout (1..65535).
- REQ-002 SHALL have one clock and a synchronous, active-high reset; ports listed below.
- REQ-003 clk  in  1  sole clock, rising edge.
- REQ-004 reset  in  1  synchronous, active-high reset.
- REQ-005 ifetch_req  in  1  fetch request, held until ifetch_done.
- REQ-006 ifetch_addr  in  32  fetch byte address.
- REQ-007 ifetch_rdata / ifetch_done / ifetch_err  out  32/1/1  fetch result, completion pulse, timeout flag.
- REQ-008 dmem_req, dmem_we  in  1, 1  data request, held until dmem_done; 1=write.
- REQ-009 dmem_addr, dmem_wdata  in  32, 32  data byte address, write data.
- REQ-010 dmem_be  in  4  byte enables.
- REQ-011 dmem_rdata / dmem_done / dmem_err  out  32/1/1  data result, completion pulse, timeout flag.
- REQ-012 Avalon master: address out 32, read out 1, write out 1, writedata out 32, byteenable out 4, readdata in 32, waitrequest in 1.
- REQ-013 busy  out  1  high in any state other than IDLE.

Function
- REQ-014 FSM states: IDLE, ACCESS, RESP; one transaction in flight at most.
- REQ-015 IDLE: sample requests; on grant latch addr/we/wdata/be into registers, go ACCESS next edge.
- REQ-016 Arbitration: one requester -> granted; both -> requester not granted last time wins (last_grant register).
- REQ-017 Avalon outputs driven only from latched registers; stable throughout ACCESS.
- REQ-018 address = {latched_addr[31:2],2'b00}; fetch byteenable = 4'b1111, read=1, write=0.
- REQ-019 Data: write=latched_we, read=!latched_we, byteenable/writedata from latch.
- REQ-020 ACCESS: read/write high; transaction completes at first edge with waitrequest=0; readdata captured that edge; go RESP.
- REQ-021 Data request with dmem_be=4'b0000: no Avalon cycle; IDLE -> RESP directly, dmem_rdata=0, err=0.
- REQ-022 RESP: exactly one cycle; granted requester's done=1 with rdata/err valid; read/write=0; requests ignored; then IDLE.
- REQ-023 Minimum latency: req seen at edge k -> done high in cycle k+2 (zero-wait).
- REQ-024 Wait counter increments each ACCESS cycle with waitrequest=1; reaching WAIT_LIMIT -> deassert read/write, go RESP, err=1, rdata=0.
- REQ-025 rdata outputs hold last captured value outside RESP; done/err high only in RESP.
- REQ-026 Request dropped mid-ACCESS: transaction still completes; done still pulsed.

Reset
- REQ-027 On reset edge: state=IDLE, read=write=0, done=err=0, rdata=0, address/writedata=0, byteenable=0, wait counter=0, last_grant=DATA (first tie goes to fetch).
- REQ-028 Reset during ACCESS/RESP: transaction abandoned, no done pulse; read/write low in cycle after reset edge.

Structure
- REQ-029 Shared package mips_cpu_bus_pkg SHALL hold state enum (IDLE/ACCESS/RESP) and grant enum (GRANT_FETCH/GRANT_DATA).
- REQ-030 One sub-module bus_wait_timer SHALL implement the clear/enable wait counter and limit compare.

Verification
- REQ-031 ifetch_req, addr 0xBFC00000, waitrequest=0, readdata 0x24020005 -> address 0xBFC00000, read 1 cycle, ifetch_done in cycle k+2, ifetch_rdata 0x24020005.
- REQ-032 both req same cycle after reset -> fetch served first, data next; repeated tie alternates.
- REQ-033 dmem write addr 0x1003, be 4'b0100, wdata 0x00AB0000, waitrequest high 3 cycles -> address 0x1000, write held 4 cycles, signals stable, dmem_done once.
- REQ-034 WAIT_LIMIT=4, waitrequest stuck 1 -> read drops after 4 wait cycles, done=1, err=1, rdata=0.
- REQ-035 dmem_be=0000 -> no read/write assertion, dmem_done in cycle k+1.
- REQ-036 reset asserted mid-ACCESS -> read/write 0 next cycle, no done pulse, busy 0.
